// File: rtl/alu_pkg.sv
// ALU op encodings and slot-state type shared by the arbiter and its grant logic.
// Latency: none (definitions only). Backpressure: n/a.
// Build option: none here; see alu_arbiter for ALU_ARB_FIXED_PRIO_EN.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD  = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND  = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR   = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLL  = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SRL  = 4'b0101;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SRA  = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLTU = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLT  = 4'b1000;
  localparam logic [ALU_OP_W-1:0] ALU_OP_MAX  = ALU_OP_SLT;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/alu_rr_grant.sv
// Grant selector: one-hot grant plus binary index, round-robin from rr_ptr (or fixed priority).
// Latency: combinational. Backpressure: none; caller gates the grant with its own issue condition.
// Build option: ALU_ARB_FIXED_PRIO_EN selects lowest-index-wins and ignores rr_ptr.
module alu_rr_grant import alu_pkg::*; #(
  parameter  int NREQ = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

`ifdef ALU_ARB_FIXED_PRIO_EN

  logic unused_rr_ptr;
  assign unused_rr_ptr = ^rr_ptr;

  // Walk downward so the lowest requesting index is the last (winning) write.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        grant     = '0;
        grant[k]  = 1'b1;
        grant_idx = IDW'(k);
      end
    end
  end

`else

  int   idx;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDW'(idx);
      end
    end
  end

`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NREQ requesters; result lands in a one-entry response slot.
// Latency: 1 cycle accept-to-rsp_valid. Backpressure: full slot with rsp_ready=0 drops all req_ready.
// Build option: ALU_ARB_FIXED_PRIO_EN swaps round-robin for fixed lowest-index priority.
module alu_arbiter import alu_pkg::*; #(
  parameter  int XLEN = 32,
  parameter  int NREQ = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*XLEN-1:0]     req_a,
  input  logic [NREQ*XLEN-1:0]     req_b,
  input  logic [NREQ*ALU_OP_W-1:0] req_op,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [XLEN-1:0]          rsp_result,
  output logic [IDW-1:0]           rsp_id,
  output logic                     rsp_err
);

  slot_state_e           state_q, state_nxt;
  logic [NREQ-1:0]       grant;
  logic [IDW-1:0]        gidx;
  logic [IDW-1:0]        rr_ptr;
  logic                  can_issue;
  logic                  accept;
  logic                  legal;
  logic [XLEN-1:0]       sel_a, sel_b;
  logic [ALU_OP_W-1:0]   sel_op;
  logic [XLEN-1:0]       alu_a, alu_b, alu_y;
  logic [ALU_OP_W-1:0]   alu_op;
  logic [4:0]            sh;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      if (gidx == IDW'(NREQ - 1)) rr_ptr <= '0;
      else                        rr_ptr <= gidx + 1'b1;
    end
  end
`endif

  alu_rr_grant #(.NREQ(NREQ)) u_grant (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (gidx)
  );

  assign can_issue = (state_q == SLOT_EMPTY) || rsp_ready;
  assign req_ready = (!rst && can_issue) ? grant : '0;
  assign accept    = |req_ready;

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a  = sel_a  | req_a[i*XLEN +: XLEN];
        sel_b  = sel_b  | req_b[i*XLEN +: XLEN];
        sel_op = sel_op | req_op[i*ALU_OP_W +: ALU_OP_W];
      end
    end
  end

  // ALU inputs stay at zero unless a legal op is actually being accepted.
  assign legal  = (sel_op <= ALU_OP_MAX);
  assign alu_a  = (accept && legal) ? sel_a  : '0;
  assign alu_b  = (accept && legal) ? sel_b  : '0;
  assign alu_op = (accept && legal) ? sel_op : '0;
  assign sh     = alu_b[4:0];

  always_comb begin
    alu_y = '0;
    case (alu_op)
      ALU_OP_ADD:  alu_y = alu_a + alu_b;
      ALU_OP_SUB:  alu_y = alu_a - alu_b;
      ALU_OP_AND:  alu_y = alu_a & alu_b;
      ALU_OP_OR:   alu_y = alu_a | alu_b;
      ALU_OP_SLL:  alu_y = alu_a << sh;
      ALU_OP_SRL:  alu_y = alu_a >> sh;
      ALU_OP_SRA:  alu_y = $unsigned($signed(alu_a) >>> sh);
      ALU_OP_SLTU: alu_y = {{(XLEN-1){1'b0}}, (alu_a < alu_b)};
      ALU_OP_SLT:  alu_y = {{(XLEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      default:     alu_y = '0;
    endcase
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      SLOT_EMPTY: if (accept) state_nxt = SLOT_FULL;
      SLOT_FULL:  if (rsp_ready && !accept) state_nxt = SLOT_EMPTY;
      default:    state_nxt = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= SLOT_EMPTY;
    else     state_q <= state_nxt;
  end

  assign rsp_valid = (state_q == SLOT_FULL);

  // Payload only moves on accept, so a stalled slot is bit-stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_result <= '0;
      rsp_id     <= '0;
      rsp_err    <= 1'b0;
    end else if (accept) begin
      rsp_result <= legal ? alu_y : '0;
      rsp_id     <= gidx;
      rsp_err    <= !legal;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (default round-robin build), 2 requesters, XLEN=32.
module tb_alu_arbiter;

  localparam int XLEN = 32;
  localparam int NREQ = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*XLEN-1:0] req_a, req_b;
  logic [NREQ*4-1:0] req_op;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [XLEN-1:0]   rsp_result;
  logic              rsp_id;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] op);
    req_valid[i]       = v;
    req_a[i*XLEN +: XLEN] = a;
    req_b[i*XLEN +: XLEN] = b;
    req_op[i*4 +: 4]   = op;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic id,
                         input logic [31:0] res, input logic err);
    chk({tag, "_valid"},  32'(rsp_valid),  32'(v));
    chk({tag, "_id"},     32'(rsp_id),     32'(id));
    chk({tag, "_result"}, rsp_result,      res);
    chk({tag, "_err"},    32'(rsp_err),    32'(err));
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
    set_req(0, 1'b1, 32'd1, 32'd1, 4'd0);
    set_req(1, 1'b1, 32'd1, 32'd1, 4'd0);
    tick(); tick();
    @(negedge clk);
    chk_rsp("reset", 1'b0, 1'b0, 32'd0, 1'b0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);

    // 1: req0 add
    tick();
    rst = 1'b0; rsp_ready = 1'b1;
    set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
    set_req(0, 1'b1, 32'd12345, 32'd123, 4'b0000);
    @(negedge clk);
    chk("t1_req_ready", 32'(req_ready), 32'b01);

    // 2: req1 sub, issued while the slot drains
    tick();
    set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
    set_req(1, 1'b1, 32'd12345, 32'd123, 4'b0001);
    @(negedge clk);
    chk_rsp("t1_rsp", 1'b1, 1'b0, 32'd12468, 1'b0);
    chk("t2_req_ready", 32'(req_ready), 32'b10);

    // 3: both valid, ids alternate with no bubbles
    tick();
    set_req(0, 1'b1, 32'd1, 32'd2, 4'b0000);
    set_req(1, 1'b1, 32'd10, 32'd3, 4'b0001);
    @(negedge clk);
    chk_rsp("t2_rsp", 1'b1, 1'b1, 32'd12222, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      chk_rsp($sformatf("t3_rsp%0d", k), 1'b1, k[0], (k[0] ? 32'd7 : 32'd3), 1'b0);
    end

    // 4: three stall cycles, then drain + refill in one cycle
    tick();
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_rsp($sformatf("t4_stall%0d", k), 1'b1, 1'b0, 32'd3, 1'b0);
      chk($sformatf("t4_stall%0d_ready", k), 32'(req_ready), 32'd0);
      if (k < 2) tick();
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4_release_ready", 32'(req_ready), 32'b10);
    tick();
    set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    chk_rsp("t4_refill", 1'b1, 1'b1, 32'd7, 1'b0);

    // 5: illegal op, then legal ops
    tick();
    set_req(0, 1'b1, 32'd5, 32'd7, 4'b1111);
    @(negedge clk);
    chk_rsp("t5_prev", 1'b1, 1'b0, 32'd3, 1'b0);
    tick();
    set_req(0, 1'b1, 32'd100, 32'd2, 4'b0100);
    @(negedge clk);
    chk_rsp("t5_illegal", 1'b1, 1'b0, 32'd0, 1'b1);
    tick();
    set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
    set_req(1, 1'b1, 32'hFFFF_FF00, 32'd4, 4'b0110);
    @(negedge clk);
    chk_rsp("t5_sll", 1'b1, 1'b0, 32'd400, 1'b0);
    tick();
    set_req(1, 1'b1, 32'hFFFF_FFFF, 32'd1, 4'b1000);
    @(negedge clk);
    chk_rsp("t5_sra", 1'b1, 1'b1, 32'hFFFF_FFF0, 1'b0);
    tick();
    set_req(1, 1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0111);
    @(negedge clk);
    chk_rsp("t5_slt", 1'b1, 1'b1, 32'd1, 1'b0);
    tick();
    set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    chk_rsp("t5_sltu", 1'b1, 1'b1, 32'd0, 1'b0);
    tick();
    @(negedge clk);
    chk("idle_drain_valid", 32'(rsp_valid), 32'd0);

    // 6: reset while full; rr_ptr points at req1 beforehand
    tick();
    set_req(0, 1'b1, 32'd1, 32'd1, 4'b0000);
    tick();
    rst = 1'b1; rsp_ready = 1'b0;
    set_req(0, 1'b1, 32'd20, 32'd22, 4'b0000);
    set_req(1, 1'b1, 32'd9, 32'd4, 4'b0001);
    @(negedge clk);
    chk_rsp("t6_pre", 1'b1, 1'b0, 32'd2, 1'b0);
    chk("t6_rst_ready", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    chk_rsp("t6_post", 1'b0, 1'b0, 32'd0, 1'b0);
    chk("t6_first_grant", 32'(req_ready), 32'b01);
    tick();
    set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    chk_rsp("t6_rsp0", 1'b1, 1'b0, 32'd42, 1'b0);
    tick();
    set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    chk_rsp("t6_rsp1", 1'b1, 1'b1, 32'd5, 1'b0);
    tick();
    @(negedge clk);
    chk("t6_final_drain", 32'(rsp_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
